fir_unfold_ctrl: RTL and testbench

FIR_UNFOLD_CTRL -- requirements
Module: fir_unfold_ctrl

---
 rtl/fir_unfold_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fir_unfold_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_unfold_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_unfold_ctrl: serial-to-3-lane front end and coefficient bank for an  |
// | unfolded FIR; optional zero-frame flush enabled by FIR_CTRL_FLUSH_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_unfold_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [9:0] cfg_data,
  input  logic       start,
  input  logic       stop,
  input  logic       s_valid,
  input  logic [9:0] s_data,
  output logic       s_ready,
  output logic [9:0] din0,
  output logic [9:0] din1,
  output logic [9:0] din2,
  output logic       vin0,
  output logic       vin1,
  output logic       vin2,
  output logic [9:0] b0,
  output logic [9:0] b1,
  output logic [9:0] b2,
  output logic [9:0] b3,
  output logic [9:0] b4,
  output logic [9:0] b5,
  output logic [9:0] b6,
  output logic [9:0] b7,
  output logic [9:0] b8,
  output logic [9:0] b9,
  output logic [9:0] b10,
  output logic [1:0] state,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam int c_NUM_COEF = 11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_lane;
  logic [1:0] w_lane_nxt;
  logic [9:0] r_l0;
  logic [9:0] r_l1;
  logic [9:0] w_l0_nxt;
  logic [9:0] w_l1_nxt;
  logic       w_full;
  logic       w_accept;
  logic       w_stop_run;
  logic [9:0] r_din0;
  logic [9:0] r_din1;
  logic [9:0] r_din2;
  logic       r_vin;
  logic [9:0] r_coef [0:c_NUM_COEF-1];
`ifdef FIR_CTRL_FLUSH_EN
  logic [1:0] r_flush_cnt;
`endif

  assign w_accept   = (r_state == ST_RUN) && s_valid;
  assign w_stop_run = (r_state == ST_RUN) && stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_RUN;
`ifdef FIR_CTRL_FLUSH_EN
      ST_RUN:   if (stop) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush_cnt == 2'd3) w_state_nxt = ST_IDLE;
`else
      ST_RUN:   if (stop) w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane fill happens before stop is considered, so a same-cycle sample is kept.
  always_comb begin
    w_lane_nxt = r_lane;
    w_l0_nxt   = r_l0;
    w_l1_nxt   = r_l1;
    w_full     = 1'b0;
    if (w_accept) begin
      case (r_lane)
        2'd0: begin
          w_l0_nxt   = s_data;
          w_lane_nxt = 2'd1;
        end
        2'd1: begin
          w_l1_nxt   = s_data;
          w_lane_nxt = 2'd2;
        end
        default: begin
          w_full     = 1'b1;
          w_lane_nxt = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= 2'd0;
      r_l0   <= '0;
      r_l1   <= '0;
      r_din0 <= '0;
      r_din1 <= '0;
      r_din2 <= '0;
      r_vin  <= 1'b0;
    end else begin
      r_vin  <= 1'b0;
      r_l0   <= w_l0_nxt;
      r_l1   <= w_l1_nxt;
      r_lane <= w_stop_run ? 2'd0 : w_lane_nxt;
      if (w_full) begin
        r_din0 <= r_l0;
        r_din1 <= r_l1;
        r_din2 <= s_data;
        r_vin  <= 1'b1;
      end else if (w_stop_run && (w_lane_nxt != 2'd0)) begin
        r_din0 <= w_l0_nxt;
        r_din1 <= (w_lane_nxt == 2'd2) ? w_l1_nxt : 10'd0;
        r_din2 <= '0;
        r_vin  <= 1'b1;
      end
`ifdef FIR_CTRL_FLUSH_EN
      else if (r_state == ST_FLUSH) begin
        r_din0 <= '0;
        r_din1 <= '0;
        r_din2 <= '0;
        r_vin  <= 1'b1;
      end
`endif
    end
  end

`ifdef FIR_CTRL_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_flush_cnt <= 2'd0;
    else if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 2'd1;
    else                         r_flush_cnt <= 2'd0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_NUM_COEF; k++) r_coef[k] <= '0;
    end else if ((r_state == ST_IDLE) && cfg_we && (cfg_addr < 4'd11)) begin
      r_coef[cfg_addr] <= cfg_data;
    end
  end

  assign state   = r_state;
  assign busy    = (r_state != ST_IDLE);
  assign s_ready = (r_state == ST_RUN);
  assign din0    = r_din0;
  assign din1    = r_din1;
  assign din2    = r_din2;
  assign vin0    = r_vin;
  assign vin1    = r_vin;
  assign vin2    = r_vin;
  assign b0      = r_coef[0];
  assign b1      = r_coef[1];
  assign b2      = r_coef[2];
  assign b3      = r_coef[3];
  assign b4      = r_coef[4];
  assign b5      = r_coef[5];
  assign b6      = r_coef[6];
  assign b7      = r_coef[7];
  assign b8      = r_coef[8];
  assign b9      = r_coef[9];
  assign b10     = r_coef[10];

endmodule
`default_nettype wire

// File: tb/tb_fir_unfold_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_unfold_ctrl: directed vector bench for fir_unfold_ctrl; follows   |
// | FIR_CTRL_FLUSH_EN to pick the after-stop expectations.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_unfold_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [9:0] cfg_data;
  logic       start;
  logic       stop;
  logic       s_valid;
  logic [9:0] s_data;
  logic       s_ready;
  logic [9:0] din0, din1, din2;
  logic       vin0, vin1, vin2;
  logic [9:0] b [0:10];
  logic [1:0] state;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

`ifdef FIR_CTRL_FLUSH_EN
  localparam bit c_FLUSH = 1'b1;
`else
  localparam bit c_FLUSH = 1'b0;
`endif
  localparam logic [1:0] c_STOP_ST = c_FLUSH ? 2'b10 : 2'b00;

  fir_unfold_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .din0(din0), .din1(din1), .din2(din2), .vin0(vin0), .vin1(vin1), .vin2(vin2),
    .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]), .b4(b[4]), .b5(b[5]), .b6(b[6]),
    .b7(b[7]), .b8(b[8]), .b9(b[9]), .b10(b[10]), .state(state), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [9:0] data;
    logic       st, sp, sv;
    logic [9:0] sd;
    logic [1:0] es;
    logic       ev;
    logic [9:0] e0, e1, e2;
  } vec_t;

  vec_t tbl[$];
  logic [9:0] h0, h1, h2;

  task automatic add(input logic we, input logic [3:0] addr, input logic [9:0] data,
                     input logic st, input logic sp, input logic sv, input logic [9:0] sd,
                     input logic [1:0] es, input logic ev,
                     input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.st = st; v.sp = sp; v.sv = sv; v.sd = sd;
    v.es = es; v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    tbl.push_back(v);
  endtask

  // Quiet cycles following a stop edge whose visible frame was (d0,d1,d2).
  task automatic add_tail(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2);
    if (c_FLUSH) begin
      add(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, d0, d1, d2);
      h0 = d0; h1 = d1; h2 = d2;
    end
  endtask

  task automatic chk(input string name, input logic [1:0] es, input logic ev,
                     input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    n_vec++;
    if (state !== es || busy !== (es != 2'b00) || s_ready !== (es == 2'b01) ||
        vin0 !== ev || vin1 !== ev || vin2 !== ev ||
        din0 !== e0 || din1 !== e1 || din2 !== e2) begin
      n_bad++;
      $display("FAIL %s: got state=%b busy=%b rdy=%b vin=%b%b%b din=%h,%h,%h; want state=%b vin=%b din=%h,%h,%h",
               name, state, busy, s_ready, vin0, vin1, vin2, din0, din1, din2, es, ev, e0, e1, e2);
    end
  endtask

  task automatic chk_val(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] addr, input logic [9:0] data,
                       input logic st, input logic sp, input logic sv, input logic [9:0] sd);
    @(negedge clk);
    cfg_we = we; cfg_addr = addr; cfg_data = data;
    start = st; stop = sp; s_valid = sv; s_data = sd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; start = 0; stop = 0; s_valid = 0; s_data = 0;

    // Coefficient load, including an out-of-range address
    for (int k = 0; k < 11; k++)
      add(1, 4'(k), 10'(k + 1), 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 4'd12, 10'd99, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // Full frame 5,6,7 with cfg write and start ignored while running
    add(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(1, 0, 10'd100, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 10'd5, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 10'd6, 2'b01, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 10'd7, 2'b01, 1, 10'd5, 10'd6, 10'd7);
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 10'd5, 10'd6, 10'd7);
    // Partial frame 9,-3 then stop
    add(0, 0, 0, 0, 0, 1, 10'd9, 2'b01, 0, 10'd5, 10'd6, 10'd7);
    add(0, 0, 0, 0, 0, 1, 10'h3FD, 2'b01, 0, 10'd5, 10'd6, 10'd7);
    add(0, 0, 0, 0, 1, 0, 0, c_STOP_ST, 1, 10'd9, 10'h3FD, 10'd0);
    add_tail(10'd9, 10'h3FD, 10'd0);
    // start+stop together and stop alone in IDLE
    add(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, h0, h1, h2);
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, h0, h1, h2);
    // 1,2,3 then 4 with stop in the same cycle
    add(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 0, 1, 10'd1, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 0, 1, 10'd2, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 0, 1, 10'd3, 2'b01, 1, 10'd1, 10'd2, 10'd3);
    add(0, 0, 0, 0, 1, 1, 10'd4, c_STOP_ST, 1, 10'd4, 10'd0, 10'd0);
    add_tail(10'd4, 10'd0, 10'd0);
    // Third sample with stop: full frame, no padding
    add(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 0, 1, 10'h200, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 0, 1, 10'h1FF, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 1, 1, 10'd13, c_STOP_ST, 1, 10'h200, 10'h1FF, 10'd13);
    add_tail(10'h200, 10'h1FF, 10'd13);
    // Stop at lane 0 with nothing pending
    add(0, 0, 0, 1, 0, 0, 0, 2'b01, 0, h0, h1, h2);
    add(0, 0, 0, 0, 1, 0, 0, c_STOP_ST, 0, h0, h1, h2);
    add_tail(h0, h1, h2);

    #3;
    chk("reset_outputs", 2'b00, 0, 0, 0, 0);
    chk_val("reset_b10", b[10], 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].st, tbl[i].sp, tbl[i].sv, tbl[i].sd);
      chk($sformatf("vec%0d", i), tbl[i].es, tbl[i].ev, tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    for (int k = 0; k < 11; k++)
      chk_val($sformatf("coef_b%0d", k), b[k], 10'(k + 1));

    // Async reset mid-flush (mid-idle after stop when flush is compiled out)
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 10'd7);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("pre_reset_pad", c_STOP_ST, 1, 10'd7, 10'd0, 10'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 2'b00, 0, 0, 0, 0);
    chk_val("async_reset_b0", b[0], 10'd0);
    chk_val("async_reset_b10", b[10], 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", 2'b00, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("first_edge_start", 2'b01, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("drain_idle", 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
